// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory, holds the
// fetched word and computes the next PC. Define IFETCH_PERF_CNT_EN to build the consume counter.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [15:0] imm16,
  output logic        extop,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic        consume;
  logic [5:0]  opcode;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  // Gated by rst directly so the request drops in the very cycle reset is asserted.
  assign imem_req  = (state == FETCH) && !rst;
  assign consume   = (state == HOLD) && !stall;

  assign imm16  = instr[15:0];
  assign opcode = instr[31:26];
  assign extop  = !(opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = {jr_target[31:2], 2'b00};
    else if (jump)
      next_pc = {pc_plus4[31:28], jump_idx, 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + {branch_off[29:0], 2'b00};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      instr        <= 32'h0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
            if (jr && (jr_target[1:0] != 2'b00))
              misalign_err <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (rst)
      count_q <= 32'h0;
    else if (consume)
      count_q <= count_q + 32'd1;
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: table-driven fetch/consume vectors plus
// hand-written reset, stall and wait-state sequences.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_off;
  logic        jump;
  logic [25:0] jump_idx;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [15:0] imm16;
  logic        extop;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0040)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_idx     (jump_idx),
    .jr           (jr),
    .jr_target    (jr_target),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imm16        (imm16),
    .extop        (extop),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          stall_cycles;
    logic        br;
    logic [31:0] boff;
    logic        jmp;
    logic [25:0] jidx;
    logic        jrr;
    logic [31:0] jtgt;
    logic [31:0] exp_pc;
    logic [15:0] exp_imm;
    logic        exp_extop;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect();
    branch_taken = 1'b0; branch_off = 32'h0;
    jump = 1'b0; jump_idx = 26'h0;
    jr = 1'b0; jr_target = 32'h0;
  endtask

  // Zero-wait fetch of v.rdata, optional stall with a stray ack, then a consume with v's redirects.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    check({tag, "_req"}, {31'h0, imem_req}, 32'h1);
    check({tag, "_addr"}, imem_addr, v.exp_pc);
    imem_ack = 1'b1; imem_rdata = v.rdata;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    check({tag, "_instr"}, instr, v.rdata);
    check({tag, "_imm16"}, {16'h0, imm16}, {16'h0, v.exp_imm});
    check({tag, "_extop"}, {31'h0, extop}, {31'h0, v.exp_extop});
    check({tag, "_hold_req"}, {31'h0, imem_req}, 32'h0);
    if (v.stall_cycles > 0) begin
      stall = 1'b1;
      imem_ack = 1'b1;
      for (int c = 0; c < v.stall_cycles; c++) tick();
      imem_ack = 1'b0;
      check({tag, "_stall_pc"}, pc, v.exp_pc);
      check({tag, "_stall_instr"}, instr, v.rdata);
      check({tag, "_stall_valid"}, {31'h0, instr_valid}, 32'h1);
      check({tag, "_stall_req"}, {31'h0, imem_req}, 32'h0);
      stall = 1'b0;
    end
    branch_taken = v.br; branch_off = v.boff;
    jump = v.jmp; jump_idx = v.jidx;
    jr = v.jrr; jr_target = v.jtgt;
    tick();
    clear_redirect();
    check({tag, "_next_addr"}, imem_addr, v.exp_next);
    check({tag, "_next_valid"}, {31'h0, instr_valid}, 32'h0);
  endtask

  initial begin
    //          rdata         stl br boff          jmp jidx          jr tgt           pc            imm       ext next
    vecs[0] = '{32'h3C01_1234, 5, 0, 32'h0,        0, 26'h0,        0, 32'h0,        32'h0000_0044, 16'h1234, 1, 32'h0000_0048};
    vecs[1] = '{32'h0800_0040, 0, 0, 32'h0,        1, 26'h40,       0, 32'h0,        32'h0000_0048, 16'h0040, 1, 32'h0000_0100};
    vecs[2] = '{32'h1000_FFFE, 0, 1, 32'hFFFF_FFFE, 0, 26'h0,       0, 32'h0,        32'h0000_0100, 16'hFFFE, 1, 32'h0000_00FC};
    vecs[3] = '{32'h3000_8001, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,        32'h0000_00FC, 16'h8001, 0, 32'h0000_0100};
    vecs[4] = '{32'h3800_0003, 0, 1, 32'h0000_0003, 0, 26'h0,       0, 32'h0,        32'h0000_0100, 16'h0003, 0, 32'h0000_0110};
    vecs[5] = '{32'h0000_0008, 0, 1, 32'h0000_0005, 1, 26'h3FF_FFFF, 1, 32'h0000_2002, 32'h0000_0110, 16'h0008, 1, 32'h0000_2000};
    vecs[6] = '{32'h3400_0000, 2, 1, 32'h0000_0001, 0, 26'h0,       1, 32'hFFFF_FFFC, 32'h0000_2000, 16'h0000, 0, 32'hFFFF_FFFC};
    vecs[7] = '{32'h2400_FFFF, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,        32'hFFFF_FFFC, 16'hFFFF, 1, 32'h0000_0000};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    clear_redirect();

    // Reset for two cycles, then the reset-vector request with one unacked cycle.
    tick();
    check("rst_req_c1", {31'h0, imem_req}, 32'h0);
    tick();
    check("rst_req_c2", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_misalign", {31'h0, misalign_err}, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    rst = 1'b0;
    #1;
    check("boot_req", {31'h0, imem_req}, 32'h1);
    check("boot_addr", imem_addr, 32'h0000_0040);
    check("boot_pc_plus4", pc_plus4, 32'h0000_0044);
    tick();
    check("boot_wait_valid", {31'h0, instr_valid}, 32'h0);
    check("boot_wait_addr", imem_addr, 32'h0000_0040);

    // Sequential fetch of an ori with zero-wait ack.
    imem_ack = 1'b1; imem_rdata = 32'h3508_00FF;
    tick();
    imem_ack = 1'b0;
    check("seq_valid", {31'h0, instr_valid}, 32'h1);
    check("seq_imm16", {16'h0, imm16}, 32'h0000_00FF);
    check("seq_extop", {31'h0, extop}, 32'h0);
    check("seq_pc", pc, 32'h0000_0040);
    tick();
    check("seq_next_addr", imem_addr, 32'h0000_0044);
`ifdef IFETCH_PERF_CNT_EN
    check("seq_count", fetch_count, 32'd1);
`else
    check("seq_count", fetch_count, 32'd0);
`endif

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    check("misalign_sticky", {31'h0, misalign_err}, 32'h1);
`ifdef IFETCH_PERF_CNT_EN
    check("count_total", fetch_count, 32'd9);
`else
    check("count_total", fetch_count, 32'd0);
`endif

    // Ack withheld for 3 cycles at the wrapped address; request must stay stable.
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("wait_req_%0d", c), {31'h0, imem_req}, 32'h1);
      check($sformatf("wait_addr_%0d", c), imem_addr, 32'h0);
      check($sformatf("wait_valid_%0d", c), {31'h0, instr_valid}, 32'h0);
    end

    // Reset mid-wait: request drops at once and the unit restarts at the reset vector.
    rst = 1'b1;
    #1;
    check("midrst_req_comb", {31'h0, imem_req}, 32'h0);
    tick();
    check("midrst_req", {31'h0, imem_req}, 32'h0);
    check("midrst_misalign", {31'h0, misalign_err}, 32'h0);
    check("midrst_count", fetch_count, 32'h0);
    rst = 1'b0;
    #1;
    check("restart_req", {31'h0, imem_req}, 32'h1);
    check("restart_addr", imem_addr, 32'h0000_0040);
    imem_ack = 1'b1; imem_rdata = 32'h3C01_0001;
    tick();
    imem_ack = 1'b0;
    check("restart_instr", instr, 32'h3C01_0001);
    check("restart_valid", {31'h0, instr_valid}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
